// File: rtl/machine_irq_ctrl_pkg.sv
// Shared register map, mip bit positions and bus payload types for the machine interrupt source.
package machine_irq_ctrl_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned STRB_W = REG_W / 8;
  localparam int unsigned IRQ_W  = 32;
  localparam int unsigned TIME_W = 64;

  // Byte offsets of the memory-mapped registers
  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  // mip bit indices, shared with the CSR unit
  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  // Response payload held until the consumer takes it
  typedef struct packed {
    logic             err;
    logic [REG_W-1:0] rdata;
  } resp_t;

  // Map a byte offset to a register; misaligned or unmapped offsets give REG_NONE
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[1:0] == 2'b00) begin
      if (addr == 32'(MSIP_OFF))             sel = REG_MSIP;
      else if (addr == 32'(MTIMECMP_LO_OFF)) sel = REG_CMP_LO;
      else if (addr == 32'(MTIMECMP_HI_OFF)) sel = REG_CMP_HI;
      else if (addr == 32'(MTIME_LO_OFF))    sel = REG_TIME_LO;
      else if (addr == 32'(MTIME_HI_OFF))    sel = REG_TIME_HI;
    end
    return sel;
  endfunction

  // Replace the byte lanes of old_val selected by strb with those of new_val
  function automatic logic [REG_W-1:0] merge_bytes(input logic [REG_W-1:0]  old_val,
                                                   input logic [REG_W-1:0]  new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [REG_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_irq_ctrl_sync.sv
// irq_sync2: generic two-flop level synchroniser for asynchronous inputs.
module irq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Shift the sampled level through two stages
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/machine_irq_ctrl.sv
// Machine-level interrupt source: mtime/mtimecmp/msip registers, external irq
// synchronisation and the registered pending vector feeding CSR mip.
module machine_irq_ctrl
  import machine_irq_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              ext_irq_async,
  output logic [31:0]       irq_pending
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_d, presc_q;
  logic [TIME_W-1:0]  mtime_d, mtime_q;
  logic [TIME_W-1:0]  mtimecmp_d, mtimecmp_q;
  logic               msip_d, msip_q;
  logic               mtip_d, mtip_q;
  logic               meip_d, meip_q;
  logic               resp_valid_d, resp_valid_q;
  resp_t              resp_d, resp_q;

  logic               ext_irq_sync;
  logic               accept;
  logic               tick;
  reg_sel_e           sel;
  logic [REG_W-1:0]   rd_val;

  irq_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq_async),
    .q   (ext_irq_sync)
  );

  // A new request can enter whenever the response slot is empty or draining
  assign req_ready = !resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;

  // Next-state for timer, registers and response slot
  always_comb begin
    presc_d      = presc_q;
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    rd_val       = '0;

    sel  = decode_addr(32'(req_addr));
    tick = (presc_q == PRESC_MAX);

    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    if (tick) mtime_d = mtime_q + 64'd1;

    unique case (sel)
      REG_MSIP:    rd_val = {31'd0, msip_q};
      REG_CMP_LO:  rd_val = mtimecmp_q[31:0];
      REG_CMP_HI:  rd_val = mtimecmp_q[63:32];
      REG_TIME_LO: rd_val = mtime_q[31:0];
      REG_TIME_HI: rd_val = mtime_q[63:32];
      default:     rd_val = '0;
    endcase

    if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_d.err   = (sel == REG_NONE);
      resp_d.rdata = (!req_we && sel != REG_NONE) ? rd_val : '0;
      if (req_we) begin
        // A non-empty mtime write replaces the whole counter, so any tick this cycle is lost
        unique case (sel)
          REG_MSIP:    if (req_wstrb[0]) msip_d = req_wdata[0];
          REG_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], req_wdata, req_wstrb);
          REG_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata, req_wstrb);
          REG_TIME_LO: if (|req_wstrb)
                         mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], req_wdata, req_wstrb)};
          REG_TIME_HI: if (|req_wstrb)
                         mtime_d = {merge_bytes(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
          default: ;
        endcase
      end
    end

    mtip_d = (mtime_q >= mtimecmp_q);
    meip_d = ext_irq_sync;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      mtip_q       <= 1'b0;
      meip_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      mtip_q       <= mtip_d;
      meip_q       <= meip_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  // Pending vector assembled purely from flop outputs
  always_comb begin
    irq_pending           = '0;
    irq_pending[MIP_MSIP] = msip_q;
    irq_pending[MIP_MTIP] = mtip_q;
    irq_pending[MIP_MEIP] = meip_q;
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule
